// File: rtl/rvx10_pkg.sv
// rvx10_pkg: shared types and constants for the RVX10 hazard controller.
//   mc_state_t     : multi-cycle sequencer states
//   REG_X0         : architectural zero register index
//   MC_LATENCY_MAX : largest supported multi-cycle EX occupancy
`timescale 1ns/1ps
package rvx10_pkg;

  typedef enum logic [1:0] {MC_IDLE, MC_BUSY, MC_DONE} mc_state_t;

  localparam logic [4:0] REG_X0         = 5'd0;
  localparam int         MC_LATENCY_MAX = 16;

endpackage

// File: rtl/hazard_stall_ctrl_mc_seq.sv
// mc_seq: sequencer for multi-cycle EX ops (RVX10 custom ops).
//   clk, reset : core clock, async active-high reset
//   McStartE   : level, high while a multi-cycle op sits in EX
//   busy       : stall phase of the op (IDLE with McStartE, or BUSY)
//   done       : final EX cycle of the op (DONE state)
// The op occupies EX for MC_LATENCY cycles: MC_LATENCY-1 stall cycles
// followed by one DONE cycle in which the result is captured.
`timescale 1ns/1ps
module mc_seq
  import rvx10_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic McStartE,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(MC_LATENCY);
  // The start cycle and the DONE cycle are not counted, hence L-3 for the
  // BUSY stretch. L==2 skips BUSY entirely, so the load value is unused.
  localparam logic [CW-1:0] CNT_INIT = CW'(MC_LATENCY > 2 ? MC_LATENCY - 3 : 0);

  if (MC_LATENCY < 2 || MC_LATENCY > MC_LATENCY_MAX) begin : g_bad_lat
    $error("mc_seq: MC_LATENCY out of range 2..%0d", MC_LATENCY_MAX);
  end

  mc_state_t       state;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (McStartE) begin
            state <= (MC_LATENCY == 2) ? MC_DONE : MC_BUSY;
            cnt   <= CNT_INIT;
          end
        end
        MC_BUSY: begin
          if (cnt == '0) state <= MC_DONE;
          else           cnt   <= cnt - CW'(1);
        end
        // McStartE is still high here (same instruction), so it is ignored.
        MC_DONE: state <= MC_IDLE;
        default: state <= MC_IDLE;
      endcase
    end
  end

  assign busy = ((state == MC_IDLE) && McStartE) || (state == MC_BUSY);
  assign done = (state == MC_DONE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: producer-side hazard controller for the RVX10 5-stage
// pipeline. Detects load-use hazards and EX redirects, and sequences
// multi-cycle EX ops, driving stall/flush enables for F/D/E/M registers.
//   clk, reset          : core clock, async active-high reset
//   Rs1D, Rs2D          : Decode source registers
//   RdE, ResultSrcE0    : Execute destination, 1 = load in EX
//   PCSrcE              : taken branch/jump resolved in EX
//   McStartE            : multi-cycle op present in EX (level)
//   StallF/D/E          : hold PC, IF/ID, ID/EX
//   FlushD/E/M          : clear IF/ID, ID/EX, EX/MEM
//   McBusy, McDone      : multi-cycle op in progress / final EX cycle
// Optional macro HAZARD_PERF_CNT_EN adds PerfStallCnt / PerfFlushCnt
// (cycles with StallF / FlushD, wrapping 32-bit counters).
`timescale 1ns/1ps
module hazard_stall_ctrl
  import rvx10_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdE,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        McStartE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        McBusy,
  output logic        McDone
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] PerfStallCnt,
  output logic [31:0] PerfFlushCnt
`endif
);

  logic mc_stall, mc_done;

  mc_seq #(.MC_LATENCY(MC_LATENCY)) u_mc_seq (
    .clk      (clk),
    .reset    (reset),
    .McStartE (McStartE),
    .busy     (mc_stall),
    .done     (mc_done)
  );

  logic lw_hz, idle_free, redirect, lw_stall;

  assign lw_hz     = ResultSrcE0 && (RdE != REG_X0) && ((RdE == Rs1D) || (RdE == Rs2D));
  // EX holds an ordinary instruction only when no multi-cycle op is present.
  assign idle_free = !mc_stall && !mc_done;
  assign redirect  = PCSrcE && idle_free;
  // Load-use is checked again in DONE; a redirect squashes the stall since
  // the dependent instruction in D is being flushed anyway.
  assign lw_stall  = lw_hz && !mc_stall && !redirect;

  // Outputs are forced low while reset is held, regardless of inputs.
  always_comb begin
    StallF = !reset && (mc_stall || lw_stall);
    StallD = !reset && (mc_stall || lw_stall);
    StallE = !reset && mc_stall;
    FlushD = !reset && redirect;
    FlushE = !reset && (redirect || lw_stall);
    FlushM = !reset && mc_stall;
    McBusy = !reset && (mc_stall || mc_done);
    McDone = !reset && mc_done;
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PerfStallCnt <= '0;
      PerfFlushCnt <= '0;
    end else begin
      if (StallF) PerfStallCnt <= PerfStallCnt + 32'd1;
      if (FlushD) PerfFlushCnt <= PerfFlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

  localparam int L = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic ResultSrcE0, PCSrcE, McStartE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McDone;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] PerfStallCnt, PerfFlushCnt;
  int unsigned m_s = 0, m_f = 0;
`endif

  hazard_stall_ctrl #(.MC_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .McBusy(McBusy), .McDone(McDone)
`ifdef HAZARD_PERF_CNT_EN
    , .PerfStallCnt(PerfStallCnt), .PerfFlushCnt(PerfFlushCnt)
`endif
  );

  always #5 clk = ~clk;

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McDone}
  logic [7:0] outs;
  assign outs = {StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McDone};

  int total = 0, bad = 0;
  // Reference model: cycles elapsed in current multi-cycle op, -1 if none.
  int occ = -1;
  logic [7:0] m_exp;

  typedef struct {
    logic [4:0] rs1, rs2, rde;
    logic ld, pc;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // Expected outputs from the behavioural rules for the current cycle.
  function automatic logic [7:0] model(input int o, input logic st, input logic pc,
                                       input logic ld, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [4:0] rde);
    int cur;
    logic stl, dn, idle, rd, lw;
    cur  = (o < 0 && st) ? 0 : o;
    idle = (cur < 0);
    stl  = !idle && (cur < L - 1);
    dn   = (cur == L - 1);
    rd   = idle && pc;
    lw   = ld && (rde != 0) && (rde == rs1 || rde == rs2) && !stl && !rd;
    return {stl | lw, stl | lw, stl, rd, rd | lw, stl, stl | dn, dn};
  endfunction

  function automatic int advance(input int o, input logic st);
    int cur;
    cur = (o < 0 && st) ? 0 : o;
    if (cur < 0 || cur == L - 1) return -1;
    return cur + 1;
  endfunction

  // One clock: drive after the edge, compare on the falling edge, then step the model.
  task automatic cyc(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rde, input logic ld, input logic pc, input logic st,
                     input logic use_hand, input logic [7:0] hand);
    @(posedge clk);
    #1;
    Rs1D = rs1; Rs2D = rs2; RdE = rde; ResultSrcE0 = ld; PCSrcE = pc; McStartE = st;
    m_exp = model(occ, st, pc, ld, rs1, rs2, rde);
    @(negedge clk);
    check(name, outs, use_hand ? hand : m_exp);
`ifdef HAZARD_PERF_CNT_EN
    check_int({name, "_pstall"}, int'(PerfStallCnt), int'(m_s));
    check_int({name, "_pflush"}, int'(PerfFlushCnt), int'(m_f));
    if (m_exp[7]) m_s++;
    if (m_exp[4]) m_f++;
`endif
    occ = advance(occ, st);
  endtask

  localparam logic [7:0] MC_STL = 8'b1110_0110;
  localparam logic [7:0] MC_DN  = 8'b0000_0011;
  localparam logic [7:0] LW     = 8'b1100_1000;
  localparam logic [7:0] RDR    = 8'b0001_1000;

  int n_stall;

  initial begin
    vecs[0] = '{5'd5,  5'd1,  5'd5,  1'b1, 1'b0, LW};     // lw x5 -> Rs1D
    vecs[1] = '{5'd5,  5'd1,  5'd0,  1'b0, 1'b0, 8'h00};  // bubble follows
    vecs[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 8'h00};  // x0 dest never stalls
    vecs[3] = '{5'd3,  5'd7,  5'd7,  1'b1, 1'b0, LW};     // Rs2D match
    vecs[4] = '{5'd3,  5'd4,  5'd7,  1'b1, 1'b0, 8'h00};  // no match
    vecs[5] = '{5'd7,  5'd4,  5'd7,  1'b0, 1'b0, 8'h00};  // match, not a load
    vecs[6] = '{5'd5,  5'd1,  5'd5,  1'b1, 1'b1, RDR};    // redirect beats lw
    vecs[7] = '{5'd2,  5'd1,  5'd9,  1'b0, 1'b1, RDR};    // redirect alone
    vecs[8] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b0, LW};     // x31 on both sources

    reset = 1'b1;
    Rs1D = '0; Rs2D = '0; RdE = '0; ResultSrcE0 = 0; PCSrcE = 0; McStartE = 0;
    #2;
    check("reset_state", outs, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i])
      cyc($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2, vecs[i].rde,
          vecs[i].ld, vecs[i].pc, 1'b0, 1'b1, vecs[i].exp);

    // Single op, L=4: stalls t..t+2, done t+3, idle t+4.
    cyc("op_t0", 0, 0, 0, 0, 0, 1, 1, MC_STL);
    cyc("op_t1", 5, 0, 5, 1, 1, 1, 1, MC_STL);   // lw/redirect ignored while busy
    cyc("op_t2", 0, 0, 0, 0, 0, 1, 1, MC_STL);
    cyc("op_t3", 0, 0, 0, 0, 0, 1, 1, MC_DN);
    cyc("op_t4", 0, 0, 0, 0, 0, 0, 1, 8'h00);

    // Back-to-back ops; lw evaluated again in DONE, redirect still ignored there.
    n_stall = 0;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e;
      e = (k % 4 == 3) ? MC_DN : MC_STL;
      if (k == 7) e = MC_DN | LW;
      cyc($sformatf("b2b_%0d", k), 6, 0, (k == 7) ? 5'd6 : 5'd0, k == 7,
          k == 3, 1, 1, e);
      if (StallF) n_stall++;
    end
    cyc("b2b_idle", 0, 0, 0, 0, 0, 0, 1, 8'h00);
    check_int("b2b_stalls", n_stall, 2 * (L - 1) + 1);   // 6 mc stalls + 1 lw stall in DONE

    // Reset in the middle of an op.
    cyc("rst_op_t0", 0, 0, 0, 0, 0, 1, 1, MC_STL);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("rst_async", outs, 8'h00);
    occ = -1;
`ifdef HAZARD_PERF_CNT_EN
    m_s = 0; m_f = 0;
`endif
    @(posedge clk);
    #1 reset = 1'b0; McStartE = 1'b0;
    cyc("rst_idle", 0, 0, 0, 0, 0, 0, 1, 8'h00);
    n_stall = 0;
    for (int k = 0; k < 5; k++) begin
      cyc($sformatf("rst_new_%0d", k), 0, 0, 0, 0, 0, k < 4, 0, 8'h00);
      if (StallF) n_stall++;
    end
    check_int("rst_new_stalls", n_stall, L - 1);
`ifdef HAZARD_PERF_CNT_EN
    check_int("rst_perf_stall", int'(PerfStallCnt), L - 1);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic st;
      st = ($urandom_range(0, 4) == 0) || (occ >= 0 && $urandom_range(0, 3) != 0);
      cyc("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0, st, 0, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
